// File: rtl/mini_cpu_lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder: command classes,
// DDRAM geometry, blank character and error flag positions.
package mini_cpu_lcd_pkg;

   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_HOME    = 8'h02;
   localparam logic [7:0] CMD_ENTRY   = 8'h04;
   localparam logic [7:0] CMD_DISPCTL = 8'h08;
   localparam logic [7:0] CMD_SHIFT   = 8'h10;
   localparam logic [7:0] CMD_FUNC    = 8'h20;
   localparam logic [7:0] CMD_CGRAM   = 8'h40;
   localparam logic [7:0] CMD_DDRAM   = 8'h80;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [6:0] LINE0_LAST = 7'h27;
   localparam logic [6:0] LINE1_LAST = 7'h67;
   localparam int         LINE_LEN   = 16;
   localparam int         NUM_CELLS  = 2 * LINE_LEN;

   localparam logic [7:0] CHAR_BLANK = 8'h20;

   localparam int ERR_BUSY   = 0;
   localparam int ERR_RW     = 1;
   localparam int ERR_UNINIT = 2;

   typedef enum logic [3:0] {
      CMDC_NOP,
      CMDC_CLEAR,
      CMDC_HOME,
      CMDC_ENTRY,
      CMDC_DISPCTL,
      CMDC_SHIFT,
      CMDC_FUNC,
      CMDC_CGRAM,
      CMDC_DDRAM
   } cmd_class_e;

   // The highest set bit of an instruction byte selects its class.
   function automatic cmd_class_e cmd_decode(input logic [7:0] d);
      if ((d & CMD_DDRAM) != 8'h00)   return CMDC_DDRAM;
      if ((d & CMD_CGRAM) != 8'h00)   return CMDC_CGRAM;
      if ((d & CMD_FUNC) != 8'h00)    return CMDC_FUNC;
      if ((d & CMD_SHIFT) != 8'h00)   return CMDC_SHIFT;
      if ((d & CMD_DISPCTL) != 8'h00) return CMDC_DISPCTL;
      if ((d & CMD_ENTRY) != 8'h00)   return CMDC_ENTRY;
      if ((d & CMD_HOME) != 8'h00)    return CMDC_HOME;
      if ((d & CMD_CLEAR) != 8'h00)   return CMDC_CLEAR;
      return CMDC_NOP;
   endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Next DDRAM address for a one-position cursor move, wrapping between the
// ends of the two 40-character display lines.
module lcd_addr_step
   import mini_cpu_lcd_pkg::*;
(
   input  logic [6:0] addr,
   input  logic       dir,
   output logic [6:0] addr_next
);

   always_comb begin
      addr_next = addr;
      if (dir) begin
         case (addr)
            LINE0_LAST: addr_next = LINE1_BASE;
            LINE1_LAST: addr_next = LINE0_BASE;
            default:    addr_next = addr + 7'd1;
         endcase
      end else begin
         case (addr)
            LINE0_BASE: addr_next = LINE1_LAST;
            LINE1_BASE: addr_next = LINE0_LAST;
            default:    addr_next = addr - 7'd1;
         endcase
      end
   end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Decodes HD44780-style enable strobes into commands and character writes,
// mirroring a 2x16 display with emulated busy time and sticky protocol errors.
module lcd_hd44780_responder
   import mini_cpu_lcd_pkg::*;
#(
   parameter int BUSY_SHORT = 2000,
   parameter int BUSY_LONG  = 82000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       lcd_rs,
   input  logic       lcd_en,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [6:0] cursor_addr,
   output logic       display_on,
   output logic       initialized,
   output logic       busy,
   output logic       evt_valid,
   output logic       evt_rs,
   output logic [7:0] evt_data,
   output logic [2:0] err
);

   localparam int CNT_W = $clog2(BUSY_LONG + 1);

   logic             en_q, rs_q, rw_q;
   logic [7:0]       data_q;
   logic [7:0]       cells_q [NUM_CELLS];
   logic [7:0]       cells_d [NUM_CELLS];
   logic [6:0]       cursor_q, cursor_d;
   logic             id_q, id_d;
   logic             disp_q, disp_d;
   logic             init_q, init_d;
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic             evt_valid_q, evt_valid_d;
   logic             evt_rs_q, evt_rs_d;
   logic [7:0]       evt_data_q, evt_data_d;
   logic [2:0]       err_q, err_d;
   logic [7:0]       rd_data_q, rd_data_d;

   logic             strobe, busy_block, accept;
   logic             step_dir;
   logic [6:0]       step_addr;
   logic [4:0]       wr_idx;

   assign strobe = en_q & ~lcd_en;
   // The counter reaching zero on this very edge frees the controller, so a
   // strobe landing exactly BUSY_x cycles after the previous one is accepted.
   assign busy_block = (busy_cnt_q > CNT_W'(1));
   assign accept     = strobe & ~rw_q & ~busy_block;
   assign step_dir   = rs_q ? id_q : data_q[2];
   assign wr_idx     = {cursor_q[6], cursor_q[3:0]};

   lcd_addr_step u_step (
      .addr      (cursor_q),
      .dir       (step_dir),
      .addr_next (step_addr)
   );

   always_comb begin
      cells_d     = cells_q;
      cursor_d    = cursor_q;
      id_d        = id_q;
      disp_d      = disp_q;
      init_d      = init_q;
      busy_cnt_d  = (busy_cnt_q != '0) ? busy_cnt_q - CNT_W'(1) : '0;
      evt_valid_d = 1'b0;
      evt_rs_d    = evt_rs_q;
      evt_data_d  = evt_data_q;
      err_d       = err_q;
      rd_data_d   = cells_q[rd_addr];

      if (strobe && rw_q)
         err_d[ERR_RW] = 1'b1;
      if (strobe && !rw_q && busy_block)
         err_d[ERR_BUSY] = 1'b1;

      if (accept) begin
         evt_valid_d = 1'b1;
         evt_rs_d    = rs_q;
         evt_data_d  = data_q;
         busy_cnt_d  = CNT_W'(BUSY_SHORT);
         if (rs_q) begin
            if (!init_q)
               err_d[ERR_UNINIT] = 1'b1;
            // Only the 16 visible columns of each line are mirrored.
            if (cursor_q[5:4] == 2'b00)
               cells_d[wr_idx] = data_q;
            cursor_d = step_addr;
         end else begin
            case (cmd_decode(data_q))
               CMDC_DDRAM:   cursor_d = data_q[6:0];
               CMDC_CGRAM:   ;
               CMDC_FUNC:    if (data_q[4]) init_d = 1'b1;
               CMDC_SHIFT:   if (!data_q[3]) cursor_d = step_addr;
               CMDC_DISPCTL: disp_d = data_q[2];
               CMDC_ENTRY:   id_d = data_q[1];
               CMDC_HOME: begin
                  cursor_d   = LINE0_BASE;
                  busy_cnt_d = CNT_W'(BUSY_LONG);
               end
               CMDC_CLEAR: begin
                  for (int i = 0; i < NUM_CELLS; i++)
                     cells_d[i] = CHAR_BLANK;
                  cursor_d   = LINE0_BASE;
                  id_d       = 1'b1;
                  busy_cnt_d = CNT_W'(BUSY_LONG);
               end
               CMDC_NOP:     ;
               default:      ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q        <= 1'b0;
         rs_q        <= 1'b0;
         rw_q        <= 1'b0;
         data_q      <= 8'h00;
         for (int i = 0; i < NUM_CELLS; i++)
            cells_q[i] <= CHAR_BLANK;
         cursor_q    <= LINE0_BASE;
         id_q        <= 1'b1;
         disp_q      <= 1'b0;
         init_q      <= 1'b0;
         busy_cnt_q  <= '0;
         evt_valid_q <= 1'b0;
         evt_rs_q    <= 1'b0;
         evt_data_q  <= 8'h00;
         err_q       <= 3'b000;
         rd_data_q   <= 8'h00;
      end else begin
         en_q        <= lcd_en;
         rs_q        <= lcd_rs;
         rw_q        <= lcd_rw;
         data_q      <= lcd_data;
         cells_q     <= cells_d;
         cursor_q    <= cursor_d;
         id_q        <= id_d;
         disp_q      <= disp_d;
         init_q      <= init_d;
         busy_cnt_q  <= busy_cnt_d;
         evt_valid_q <= evt_valid_d;
         evt_rs_q    <= evt_rs_d;
         evt_data_q  <= evt_data_d;
         err_q       <= err_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign cursor_addr = cursor_q;
   assign display_on  = disp_q;
   assign initialized = init_q;
   assign busy        = (busy_cnt_q != '0);
   assign evt_valid   = evt_valid_q;
   assign evt_rs      = evt_rs_q;
   assign evt_data    = evt_data_q;
   assign err         = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: expected strobe events are queued
// at issue time and matched by a monitor; state is checked against constants.
module tb_lcd_hd44780_responder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       lcd_rs, lcd_en, lcd_rw;
   logic [7:0] lcd_data;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic [6:0] cursor_addr;
   logic       display_on, initialized, busy;
   logic       evt_valid, evt_rs;
   logic [7:0] evt_data;
   logic [2:0] err;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;

   always #5 clk = ~clk;

   lcd_hd44780_responder #(.BUSY_SHORT(4), .BUSY_LONG(10)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .lcd_rs      (lcd_rs),
      .lcd_en      (lcd_en),
      .lcd_rw      (lcd_rw),
      .lcd_data    (lcd_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .cursor_addr (cursor_addr),
      .display_on  (display_on),
      .initialized (initialized),
      .busy        (busy),
      .evt_valid   (evt_valid),
      .evt_rs      (evt_rs),
      .evt_data    (evt_data),
      .err         (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Event monitor: every evt_valid pulse must match the oldest queued strobe.
   always @(negedge clk) begin
      if (evt_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL evt_unexpected actual=%0h required=none", {evt_rs, evt_data});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({evt_rs, evt_data} !== mon_exp) begin
               errors++;
               $display("FAIL evt_match actual=%0h required=%0h", {evt_rs, evt_data}, mon_exp);
            end
         end
      end
   end

   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input logic expect_evt);
      @(posedge clk); #1;
      lcd_rs   = rs;
      lcd_rw   = rw;
      lcd_data = d;
      lcd_en   = 1'b1;
      if (expect_evt) exp_q.push_back({rs, d});
      @(posedge clk); #1;
      lcd_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      @(posedge clk); #1;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic cmd(input logic [7:0] d);
      strobe(1'b0, 1'b0, d, 1'b1);
      wait_idle();
   endtask

   task automatic wr(input logic [7:0] d);
      strobe(1'b1, 1'b0, d, 1'b1);
      wait_idle();
   endtask

   task automatic rd_chk(input logic [4:0] a, input logic [7:0] e);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      chk($sformatf("cell%0d", a), {24'd0, rd_data}, {24'd0, e});
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int cnt;
      reset_n  = 1'b0;
      lcd_rs   = 1'b0;
      lcd_en   = 1'b0;
      lcd_rw   = 1'b0;
      lcd_data = 8'h00;
      rd_addr  = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cursor", {25'd0, cursor_addr}, 32'd0);
      chk("rst_display_on", {31'd0, display_on}, 32'd0);
      chk("rst_initialized", {31'd0, initialized}, 32'd0);
      chk("rst_err", {29'd0, err}, 32'd0);
      chk("rst_evt", {23'd0, evt_valid, evt_rs, evt_data}, 32'd0);
      chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd_chk(5'd5, 8'h20);

      // Read strobe is rejected and only flags err[1].
      strobe(1'b0, 1'b1, 8'h38, 1'b0);
      repeat (3) @(negedge clk);
      chk("rw_err", {29'd0, err}, 32'h2);
      chk("rw_no_init", {31'd0, initialized}, 32'd0);
      chk("rw_no_busy", {31'd0, busy}, 32'd0);

      // Data before function set still lands.
      wr(8'h5A);
      rd_chk(5'd0, 8'h5A);
      chk("uninit_err", {29'd0, err}, 32'h6);
      chk("uninit_cursor", {25'd0, cursor_addr}, 32'h01);

      // Reset while busy.
      strobe(1'b0, 1'b0, 8'h38, 1'b1);
      @(posedge clk);
      @(negedge clk); #1;
      chk("midbusy_busy", {31'd0, busy}, 32'd1);
      chk("midbusy_init", {31'd0, initialized}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rstbusy_busy", {31'd0, busy}, 32'd0);
      chk("rstbusy_err", {29'd0, err}, 32'd0);
      chk("rstbusy_init", {31'd0, initialized}, 32'd0);
      chk("rstbusy_cursor", {25'd0, cursor_addr}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      cmd(8'h38);
      cmd(8'h0C);
      cmd(8'h06);
      cmd(8'h01);
      wr(8'h41);
      chk("init_initialized", {31'd0, initialized}, 32'd1);
      chk("init_display_on", {31'd0, display_on}, 32'd1);
      chk("init_cursor", {25'd0, cursor_addr}, 32'h01);
      chk("init_err", {29'd0, err}, 32'd0);
      rd_chk(5'd0, 8'h41);

      cmd(8'hC0);
      wr(8'h42);
      rd_chk(5'd16, 8'h42);
      chk("line1_cursor", {25'd0, cursor_addr}, 32'h41);
      cmd(8'hA7);
      wr(8'h43);
      chk("wrap_27_40", {25'd0, cursor_addr}, 32'h40);
      rd_chk(5'd7, 8'h20);
      cmd(8'h04);
      wr(8'h44);
      chk("wrap_40_27", {25'd0, cursor_addr}, 32'h27);
      rd_chk(5'd16, 8'h44);
      cmd(8'h80);
      wr(8'h45);
      chk("wrap_00_67", {25'd0, cursor_addr}, 32'h67);
      rd_chk(5'd0, 8'h45);
      cmd(8'h06);
      cmd(8'hE7);
      wr(8'h46);
      chk("wrap_67_00", {25'd0, cursor_addr}, 32'h00);
      rd_chk(5'd23, 8'h20);

      cmd(8'h14);
      chk("shift_right", {25'd0, cursor_addr}, 32'h01);
      cmd(8'h10);
      chk("shift_left", {25'd0, cursor_addr}, 32'h00);
      cmd(8'h1C);
      chk("display_shift", {25'd0, cursor_addr}, 32'h00);
      cmd(8'h40);
      chk("cgram_nochange", {25'd0, cursor_addr}, 32'h00);
      cmd(8'h08);
      chk("display_off", {31'd0, display_on}, 32'd0);
      cmd(8'h8A);
      cmd(8'h02);
      chk("home_cursor", {25'd0, cursor_addr}, 32'h00);
      chk("pre_busy_err", {29'd0, err}, 32'd0);

      // Second strobe two cycles after the first lands in busy.
      strobe(1'b0, 1'b0, 8'h85, 1'b1);
      strobe(1'b0, 1'b0, 8'h81, 1'b0);
      wait_idle();
      chk("busy_viol_err", {29'd0, err}, 32'h1);
      chk("busy_viol_cursor", {25'd0, cursor_addr}, 32'h05);
      // Four cycles after the first is accepted.
      strobe(1'b0, 1'b0, 8'h81, 1'b1);
      repeat (2) @(posedge clk);
      strobe(1'b0, 1'b0, 8'h83, 1'b1);
      wait_idle();
      chk("busy_edge_cursor", {25'd0, cursor_addr}, 32'h03);
      chk("busy_edge_err", {29'd0, err}, 32'h1);

      strobe(1'b0, 1'b0, 8'h01, 1'b1);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) cnt++;
         else if (cnt > 0) break;
      end
      chk("clear_busy_len", cnt, 32'd10);
      chk("clear_cursor", {25'd0, cursor_addr}, 32'd0);
      for (int i = 0; i < 32; i++) rd_chk(5'(i), 8'h20);

      repeat (4) @(negedge clk);
      chk("evt_queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

Synthesizable responder for the HD44780-style 8-bit write bus that module_mini_cpu drives (LCD_RS/LCD_EN/LCD_RW/LCD_DATA). It decodes every enable strobe into a command or a character write and keeps a 2x16 character mirror, cursor and display state. It models controller busy time and flags protocol violations. It provides a self-checking observation point for the CPU's display path in simulation and an on-chip debug mirror on the board.

## Interface
- BUSY_SHORT, 2000: busy cycles after ordinary commands and data writes (40 us at 50 MHz).
- BUSY_LONG, 82000: busy cycles after clear (0x01) and return-home (0x02/0x03) (1.64 ms).
- clk  in  1  system clock, same domain as the LCD bus driver.
- reset_n  in  1  asynchronous active-low reset.
- lcd_rs, lcd_en, lcd_rw  in  1 each  bus controls from the CPU.
- lcd_data  in  8  bus data.
- rd_addr  in  5  mirror read address: 0-15 = line 0, 16-31 = line 1.
- rd_data  out  8  character at rd_addr, registered.
- cursor_addr  out  7  current DDRAM address.
- display_on  out  1  D bit of the last display-control command.
- initialized  out  1  set by the first function set with DL=1 (8-bit mode).
- busy  out  1  emulated busy flag.
- evt_valid  out  1  one-cycle pulse per accepted strobe.
- evt_rs  out  1  RS of the accepted strobe.
- evt_data  out  8  data of the accepted strobe.
- err  out  3  sticky error flags:
  - bit0: strobe while busy.
  - bit1: strobe with lcd_rw=1.
  - bit2: data write before initialization.

## Operation
- Strobe capture:
  - lcd_rs, lcd_rw, lcd_data and lcd_en are registered every cycle.
  - A strobe is detected when the registered lcd_en=1 and the current lcd_en=0.
  - The strobe uses the registered rs/rw/data, i.e. values from the last cycle en was high.
- Strobe rejection:
  - rw=1: ignored; set err[1].
  - busy=1: ignored; set err[0]; busy counter not reloaded; no evt_valid.
- RS=0 command decode (highest set bit wins):
  - 0x80-0xFF: cursor_addr = data[6:0].
  - 0x40-0x7F: CGRAM address set; accepted, no state change.
  - 0x20-0x3F: function set; if DL (bit4)=1, set initialized.
  - 0x10-0x1F: shift command.
    - S/C (bit3)=0: cursor moves by ±1 per R/L (bit2) using the step rule.
    - S/C=1: display shift; no effect.
  - 0x08-0x0F: display_on = bit2; cursor and blink bits are ignored.
  - 0x04-0x07: I/D = bit1; S is ignored.
  - 0x02-0x03: cursor_addr = 0; uses BUSY_LONG.
  - 0x01: all 32 cells = 0x20, cursor_addr = 0, I/D = 1; uses BUSY_LONG.
  - 0x00: no-op, still starts BUSY_SHORT.
- RS=1 data write:
  - If cursor_addr is 0x00-0x0F or 0x40-0x4F, store data in cell (addr[6] ? 16 : 0) + addr[3:0]; otherwise drop it.
  - Cursor then steps per I/D.
  - If initialized=0, the write still takes effect and err[2] is set.
- Step rule:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Addresses 0x28-0x3F and 0x68-0x7F, reachable only by set-address, step by ±1 without wrap.
- Every accepted strobe:
  - pulses evt_valid with evt_rs/evt_data;
  - loads the busy counter; busy=1 for exactly BUSY_SHORT or BUSY_LONG cycles.

## Timing
- Strobe detection: state is updated, busy=1 and evt_valid=1 at the clock edge where en falls; all are visible on the next cycle.
- Read port: rd_data reflects rd_addr after 1 cycle. A write to the same cell in the same cycle returns the old value (read-before-write).
- Busy: deasserts exactly N cycles after assertion. A strobe on the first cycle busy=0 is accepted.
- Reset values:
  - all cells 0x20;
  - cursor_addr 0, I/D 1;
  - display_on 0, initialized 0, busy 0;
  - evt_valid 0, evt_rs 0, evt_data 0x00;
  - err 0, rd_data 0x00.
- Reset mid-busy or mid-strobe: everything returns to reset values immediately. An en falling edge in the first cycle after release is not a strobe, because the registered en reset to 0.
- Err bits clear only on reset.

## Structure
- Shared package mini_cpu_lcd_pkg holds:
  - command class masks (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPCTL, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM);
  - DDRAM line bases 7'h00 and 7'h40, and LINE_LEN = 16;
  - the blank character 8'h20;
  - err bit indices.
- Sub-module lcd_addr_step: combinational; inputs addr and dir; outputs the next address under the wrap rule.

## Test plan
- Init and write: after reset, strobe 0x38, 0x0C, 0x06, 0x01, then RS=1 0x41 → initialized=1, display_on=1, rd_addr 0 = 0x41, cursor_addr=0x01, err=0.
- Line 2 and wrap:
  - 0xC0 then 0x42 → rd_addr 16 = 0x42.
  - 0xA7 then 0x43 → data dropped, cursor_addr=0x40.
  - Entry 0x04 at 0x40, then write → cursor_addr=0x27.
- Busy violation (BUSY_SHORT=4): second strobe 2 cycles after the first → ignored, err[0]=1, no evt_valid. A strobe exactly 4 cycles after the first → accepted.
- Clear timing (BUSY_LONG=10): 0x01 → busy high exactly 10 cycles, all 32 cells read 0x20.
- Protocol errors: strobe with rw=1 → err[1]=1, no change. RS=1 0x5A before any function set → cell 0 = 0x5A, err[2]=1.
- Reset mid-busy: assert reset_n=0 during busy → busy, err and cells back to reset values; the next strobe after release is accepted.
- End-to-end: connect to module_mini_cpu with FAST_SIM=1, run LOAD R1,+5; ADD R2=R1+R1; DISPLAY R2 → line 0 mirror contains the CPU's rendering of value 10 and err=0.
